// File: rtl/reg_dump_pkg.sv
// ----------------------------------------------------------------------------
// reg_dump_pkg
// Shared types and constants for the register-file dump engine (reg_dump) and
// its byte serializer (reg_dump_ser).
// ----------------------------------------------------------------------------
package reg_dump_pkg;

    localparam int unsigned REG_IDX_W      = 5;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BCNT_W         = 2;

    // Dump sequencer states; CSUM is only reachable with REG_DUMP_CSUM_EN.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        SEND     = 3'd2,
        CSUM     = 3'd3,
        DONE     = 3'd4
    } state_e;

    // Select byte 'sel' of a word; byte 0 is bits 7:0.
    function automatic logic [BYTE_W-1:0] word_byte(
        input logic [DATA_W-1:0] word,
        input logic [BCNT_W-1:0] sel
    );
        word_byte = word[{sel, 3'b000} +: BYTE_W];
    endfunction

endpackage : reg_dump_pkg

// File: rtl/reg_dump_ser.sv
// ----------------------------------------------------------------------------
// reg_dump_ser
// Word-to-byte serializer with a valid/ready byte output. A loaded 32-bit word
// is presented LSB byte first; each accepted byte advances to the next with no
// bubble. A single byte may also be loaded (used for the checksum), which is
// treated as the last byte of its group.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_load_word     capture i_word and present its byte 0
//   i_word          32-bit word to serialize
//   i_load_byte     present i_byte as a lone final byte
//   i_byte          single byte to present
//   i_stop          drop valid after the current transfer (abort)
//   i_tx_ready      sink accepts the presented byte
//   o_tx_data       presented byte (registered)
//   o_tx_valid      presented byte is valid (registered)
//   o_xfer_c        transfer happens this cycle (combinational)
//   o_last_c        presented byte is the last of its group (combinational)
// ----------------------------------------------------------------------------
module reg_dump_ser
    import reg_dump_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_word,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_load_byte,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_stop,
    input  logic              i_tx_ready,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    output logic              o_xfer_c,
    output logic              o_last_c
);

    logic [DATA_W-1:0] r_word;
    logic [BCNT_W-1:0] r_bcnt;
    logic [BYTE_W-1:0] r_data;
    logic              r_valid;
    logic [BCNT_W-1:0] w_bcnt_nxt;

    assign o_xfer_c   = r_valid & i_tx_ready;
    assign o_last_c   = (r_bcnt == BCNT_W'(BYTES_PER_WORD - 1));
    assign w_bcnt_nxt = r_bcnt + BCNT_W'(1);

    // Byte pointer, output byte and valid; data only changes on load or transfer,
    // so it is stable while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_bcnt  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load_word) begin
            r_word  <= i_word;
            r_bcnt  <= '0;
            r_data  <= word_byte(i_word, BCNT_W'(0));
            r_valid <= 1'b1;
        end else if (i_load_byte) begin
            // A lone byte is marked as last so its transfer ends the group.
            r_bcnt  <= BCNT_W'(BYTES_PER_WORD - 1);
            r_data  <= i_byte;
            r_valid <= 1'b1;
        end else if (o_xfer_c) begin
            if (o_last_c || i_stop) begin
                r_valid <= 1'b0;
            end else begin
                r_bcnt  <= w_bcnt_nxt;
                r_data  <= word_byte(r_word, w_bcnt_nxt);
            end
        end
    end

    assign o_tx_data  = r_data;
    assign o_tx_valid = r_valid;

endmodule : reg_dump_ser

// File: rtl/reg_dump.sv
// ----------------------------------------------------------------------------
// reg_dump
// Debug-port reader for the register file. On a start request it walks
// x0..x(NUM_REGS-1) through the register file debug mux, captures each 32-bit
// value when the register file reports ready, and streams it out as four
// bytes, LSB first, over a valid/ready byte interface (towards the debug UART).
// If the register file drops ready while a word is being sent, the byte in
// flight is completed and the dump ends with err=1.
//
// Optional feature (macro REG_DUMP_CSUM_EN): an 8-bit XOR checksum of all data
// bytes is sent as one extra byte after the last data byte of a full dump.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle dump request, honoured only when idle
//   rf_rdy          register file ready
//   dbg_reg_sel     register index for the debug mux
//   dbg_reg_data    debug read data (combinational from dbg_reg_sel)
//   tx_data         byte to transmit
//   tx_valid        tx_data valid
//   tx_ready        sink accepts byte
//   busy            dump in progress
//   done            one-cycle pulse at end of dump
//   err             qualifies done: dump was aborted
// ----------------------------------------------------------------------------
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rf_rdy,
    output logic [REG_IDX_W-1:0] dbg_reg_sel,
    input  logic [DATA_W-1:0]    dbg_reg_data,
    output logic [BYTE_W-1:0]    tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   r_start;
    logic                   r_abort;
    logic [REG_IDX_W-1:0]   r_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic                   w_load_word;
    logic                   w_load_byte;
    logic                   w_stop;
    logic                   w_err_nxt;
    logic                   w_idx_clr;
    logic                   w_idx_inc;
    logic                   w_xfer;
    logic                   w_last;
    logic [BYTE_W-1:0]      w_csum_byte;
    logic [BYTE_W-1:0]      w_tx_data;

    // Start request is registered and only accepted while idle, so a request
    // during a dump or coincident with done never queues a new dump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
        end else begin
            r_start <= start && (r_state == IDLE);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control.
    always_comb begin
        w_state_nxt = r_state;
        w_load_word = 1'b0;
        w_load_byte = 1'b0;
        w_stop      = 1'b0;
        w_err_nxt   = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_start) begin
                    w_idx_clr   = 1'b1;
                    w_state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (rf_rdy) begin
                    w_load_word = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_xfer) begin
                    if (r_abort || !rf_rdy) begin
                        // Ready dropped during this word: finish the byte, then abort.
                        w_stop      = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end else if (w_last) begin
                        if (r_idx == LAST_IDX) begin
`ifdef REG_DUMP_CSUM_EN
                            w_load_byte = 1'b1;
                            w_state_nxt = CSUM;
`else
                            w_state_nxt = DONE;
`endif
                        end else begin
                            w_idx_inc   = 1'b1;
                            w_state_nxt = WAIT_RDY;
                        end
                    end
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Register index; never advances past the last dumped register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_idx_clr) begin
            r_idx <= '0;
        end else if (w_idx_inc) begin
            r_idx <= r_idx + REG_IDX_W'(1);
        end
    end

    // Sticky abort: any SEND cycle with rf_rdy low aborts at the next transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort <= 1'b0;
        end else if (w_load_word) begin
            r_abort <= 1'b0;
        end else if ((r_state == SEND) && !rf_rdy) begin
            r_abort <= 1'b1;
        end
    end

`ifdef REG_DUMP_CSUM_EN
    logic [BYTE_W-1:0] r_csum;

    // Running XOR of every transferred data byte, cleared when a dump starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_idx_clr) begin
            r_csum <= '0;
        end else if ((r_state == SEND) && w_xfer) begin
            r_csum <= r_csum ^ w_tx_data;
        end
    end

    // Includes the last data byte, which transfers in the same cycle the checksum loads.
    assign w_csum_byte = r_csum ^ w_tx_data;
`else
    assign w_csum_byte = '0;
`endif

    // Status outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == WAIT_RDY) || (w_state_nxt == SEND) ||
                      (w_state_nxt == CSUM);
            r_done <= (w_state_nxt == DONE) && (r_state != DONE);
            r_err  <= (w_state_nxt == DONE) && (r_state != DONE) && w_err_nxt;
        end
    end

    reg_dump_ser u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load_word (w_load_word),
        .i_word      (dbg_reg_data),
        .i_load_byte (w_load_byte),
        .i_byte      (w_csum_byte),
        .i_stop      (w_stop),
        .i_tx_ready  (tx_ready),
        .o_tx_data   (w_tx_data),
        .o_tx_valid  (tx_valid),
        .o_xfer_c    (w_xfer),
        .o_last_c    (w_last)
    );

    assign tx_data     = w_tx_data;
    assign dbg_reg_sel = r_idx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule : reg_dump

// File: tb/tb_reg_dump.sv
// ----------------------------------------------------------------------------
// tb_reg_dump
// Self-checking bench for reg_dump (NUM_REGS=4). A register-file model answers
// the debug mux; the expected byte stream is computed from the register array.
// ----------------------------------------------------------------------------
module tb_reg_dump;

    localparam int unsigned NREGS  = 4;
    localparam int          BUDGET = 3000;
`ifdef REG_DUMP_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        rf_rdy   = 1'b0;
    logic        tx_ready = 1'b0;
    logic [4:0]  dbg_reg_sel;
    logic [31:0] dbg_reg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] rf [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign dbg_reg_data = rf[dbg_reg_sel];

    reg_dump #(.NUM_REGS(NREGS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rf_rdy       (rf_rdy),
        .dbg_reg_sel  (dbg_reg_sel),
        .dbg_reg_data (dbg_reg_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One dump: start, drive the sink/ready patterns, collect bytes, compare.
    // ready_mode: 0 always ready, 1 pattern 1-0-0-1, 2 random.
    // abort_idx >= 0 drops rf_rdy while that byte is presented.
    // rdy_delay > 0 holds rf_rdy low until that cycle.
    // rst_at > 0 asserts reset at that cycle and ends the dump there.
    // noise adds a start while busy and random rf_rdy gaps between words.
    task automatic run_dump(input string tag, input int ready_mode, input int abort_idx,
                            input int rdy_delay, input int rst_at, input bit noise);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] cs;
        logic [7:0] stall_data;
        logic       stall;
        logic       err_v;
        logic       busy_v;
        logic       quiet;
        int         cyc;
        int         first_v;
        int         last_x;
        int         done_c;
        int         exp_first;

        cs = 8'h00;
        for (int r = 0; r < int'(NREGS); r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((rf[r] >> (8 * b)) & 32'hFF));
        if (abort_idx >= 0) begin
            while (exp_q.size() > abort_idx + 1) void'(exp_q.pop_back());
        end else if (CSUM_ON) begin
            foreach (exp_q[i]) cs = cs ^ exp_q[i];
            exp_q.push_back(cs);
        end

        @(negedge clk);
        start      = 1'b1;
        rf_rdy     = (rdy_delay == 0);
        tx_ready   = 1'b1;
        cyc        = 0;
        first_v    = -1;
        last_x     = -1;
        done_c     = -1;
        err_v      = 1'b0;
        busy_v     = 1'b1;
        stall      = 1'b0;
        stall_data = 8'h00;

        while (done_c < 0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start = noise && (cyc == 10);
            if (rst_at > 0 && cyc == rst_at) begin
                check_eq({tag, "_pre_rst_valid"}, 32'(tx_valid), 32'd1);
                rst_n = 1'b0;
                #1;
                check_eq({tag, "_rst_valid"}, 32'(tx_valid), 32'd0);
                check_eq({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check_eq({tag, "_rst_sel"}, 32'(dbg_reg_sel), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (stall) begin
                check_eq({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
                check_eq({tag, "_hold_data"}, 32'(tx_data), 32'(stall_data));
            end
            if (rdy_delay > 0 && cyc == rdy_delay) begin
                check_eq({tag, "_wait_busy"}, 32'(busy), 32'd1);
                check_eq({tag, "_wait_valid"}, 32'(tx_valid), 32'd0);
                rf_rdy = 1'b1;
            end
            if (tx_valid && first_v < 0) first_v = cyc;
            if (done) begin
                done_c = cyc;
                err_v  = err;
                busy_v = busy;
            end
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (noise && first_v >= 0 && !tx_valid && done_c < 0)
                rf_rdy = ($urandom_range(0, 2) != 0);
            if (abort_idx >= 0 && tx_valid && got_q.size() == abort_idx)
                rf_rdy = 1'b0;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                last_x = cyc;
            end
            stall      = tx_valid && !tx_ready;
            stall_data = tx_data;
        end

        check_eq({tag, "_done_seen"}, 32'(done_c >= 0), 32'd1);
        if (done_c >= 0) begin
            // A start in the done cycle must be ignored.
            start = 1'b1;
            quiet = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                start = 1'b0;
                quiet = quiet && !busy && !tx_valid && !done;
            end
            check_eq({tag, "_quiet_after_done"}, 32'(quiet), 32'd1);
            check_eq({tag, "_err"}, 32'(err_v), 32'(abort_idx >= 0));
            check_eq({tag, "_busy_at_done"}, 32'(busy_v), 32'd0);
            check_eq({tag, "_done_lat"}, 32'(done_c), 32'(last_x + 1));
            check_eq({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++)
                check_eq($sformatf("%s_byte%0d", tag, i),
                         (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
                         32'(exp_q[i]));
            exp_first = (rdy_delay > 0) ? rdy_delay + 1 : 3;
            check_eq({tag, "_first_valid"}, 32'(first_v), 32'(exp_first));
            // Full-rate dump: one idle cycle between consecutive words only.
            if (ready_mode == 0 && !noise && abort_idx < 0 && rdy_delay == 0)
                check_eq({tag, "_last_xfer"}, 32'(last_x),
                         32'(3 + (exp_q.size() - 1) + (int'(NREGS) - 1)));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_sel",   32'(dbg_reg_sel), 32'd0);
        check_eq("reset_data",  32'(tx_data),     32'd0);
        check_eq("reset_valid", 32'(tx_valid),    32'd0);
        check_eq("reset_busy",  32'(busy),        32'd0);
        check_eq("reset_done",  32'(done),        32'd0);
        check_eq("reset_err",   32'(err),         32'd0);
        rst_n = 1'b1;

        rf[0] = 32'h0000_0000;
        rf[1] = 32'h1234_5678;
        rf[2] = 32'hDEAD_BEEF;
        rf[3] = 32'h0000_0001;
        run_dump("basic",     0, -1, 0, 0, 1'b0);
        run_dump("backpres",  1, -1, 0, 0, 1'b0);
        run_dump("rdy_late",  0, -1, 5, 0, 1'b0);
        run_dump("abort",     0,  9, 0, 0, 1'b0);
        run_dump("rst_mid",   0, -1, 0, 8, 1'b0);
        run_dump("after_rst", 0, -1, 0, 0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < 32; r++) rf[r] = $urandom;
            run_dump($sformatf("rand%0d", it), 2, -1, 0, 0, 1'b1);
        end
        for (int it = 0; it < 4; it++) begin
            for (int r = 0; r < 32; r++) rf[r] = $urandom;
            run_dump($sformatf("rabort%0d", it), 1, int'($urandom_range(0, 15)), 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reg_dump
